// File: rtl/pipeexe_md_if.sv
// EX-stage bundle for pipeexe_md: ID/EX operands and controls in, result and multiplier status out.
// The master side is the pipeline (ID/EX register). The slave side is the execute unit.
interface pipeexe_md_if;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [31:0] epc4;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [4:0]  ern0;
  logic        emul;
  logic [31:0] ealu;
  logic [4:0]  ern;
  logic        ebusy;
  logic        emdone;
  logic [31:0] ehi;
  logic [31:0] elo;

  modport master (
    output ealuc, ealuimm, eshift, ejal, epc4, ea, eb, eimm, ern0, emul,
    input  ealu, ern, ebusy, emdone, ehi, elo
  );

  modport slave (
    input  ealuc, ealuimm, eshift, ejal, epc4, ea, eb, eimm, ern0, emul,
    output ealu, ern, ebusy, emdone, ehi, elo
  );
endinterface

// File: rtl/pipeexe_md.sv
// Pipeline EX stage: combinational ALU with jal link path, plus an optional sequential
// 32x32 unsigned shift-add multiplier, built only when EXE_MUL_EN is defined.
module pipeexe_md (
  input logic         clock,
  input logic         resetn,
  pipeexe_md_if.slave ex
);

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;

  always_comb begin
    op_a = ex.eshift ? {27'b0, ex.eimm[10:6]} : ex.ea;
    op_b = ex.ealuimm ? ex.eimm : ex.eb;
  end

  always_comb begin
    alu_res = '0;
    casez (ex.ealuc)
      4'b?000: alu_res = op_a + op_b;
      4'b?100: alu_res = op_a - op_b;
      4'b?001: alu_res = op_a & op_b;
      4'b?101: alu_res = op_a | op_b;
      4'b?010: alu_res = op_a ^ op_b;
      4'b?110: alu_res = {op_b[15:0], 16'b0};
      4'b0011: alu_res = op_b << op_a[4:0];
      4'b0111: alu_res = op_b >> op_a[4:0];
      4'b1111: alu_res = $signed(op_b) >>> op_a[4:0];
      default: alu_res = '0;
    endcase
  end

  // jal writes the link address (PC+8) into r31.
  assign ex.ealu = ex.ejal ? ex.epc4 + 32'd4 : alu_res;
  assign ex.ern  = ex.ern0 | {5{ex.ejal}};

`ifdef EXE_MUL_EN
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (ex.emul) begin
          state_d  = StRun;
          cnt_d    = '0;
          mcand_d  = {32'b0, ex.ea};
          mplier_d = ex.eb;
          acc_d    = '0;
        end
      end
      StRun: begin
        // Multiplicand walks left while the multiplier bit under test walks right.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = acc_d[63:32];
          lo_d    = acc_d[31:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign ex.ebusy  = (state_q == StRun);
  assign ex.emdone = done_q;
  assign ex.ehi    = hi_q;
  assign ex.elo    = lo_q;
`else
  logic unused_mul;
  assign unused_mul = ex.emul ^ clock ^ resetn;

  assign ex.ebusy  = 1'b0;
  assign ex.emdone = 1'b0;
  assign ex.ehi    = '0;
  assign ex.elo    = '0;
`endif

endmodule

// File: doc/pipeexe_md.md
PIPEEXE_MD -- requirements
Module: pipeexe_md

Interface
REQ-001 SHALL provide ports: clock  in  1  pipeline clock, rising-edge active.
REQ-002 SHALL provide: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: ealuc  in  4  ALU operation code from the ID/EX register.
REQ-004 SHALL provide: ealuimm  in  1  select eimm as operand B; eshift  in  1  select eimm[10:6] as operand A.
REQ-005 SHALL provide: ejal  in  1  jump-and-link; epc4  in  32  PC+4 of the instruction.
REQ-006 SHALL provide: ea, eb, eimm  in  32 each  register operands and extended immediate.
REQ-007 SHALL provide: ern0  in  5  destination register number; emul  in  1  start unsigned 32x32 multiply.
REQ-008 SHALL provide: ealu  out  32  EX result; ern  out  5  final destination register.
REQ-009 SHALL provide: ebusy  out  1  multiplier active, stall request to upstream stages.
REQ-010 SHALL provide: emdone  out  1  one-cycle completion pulse; ehi, elo  out  32 each  product high/low words.

Function
REQ-011 Operand A SHALL be eshift ? {27'b0, eimm[10:6]} : ea; operand B SHALL be ealuimm ? eimm : eb.
REQ-012 ALU SHALL decode ealuc (x = don't care): x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui (B[15:0]<<16), 0011 sll, 0111 srl, 1111 sra; shift amount SHALL be A[4:0], shifted value B.
REQ-013 Add/sub SHALL wrap modulo 2^32; no overflow flag.
REQ-014 ealu SHALL be combinational: ejal ? epc4+4 : ALU result; ern SHALL be ern0 | {5{ejal}}.
REQ-015 Multiplier SHALL use an Idle/Run FSM with a 6-bit iteration counter.
REQ-016 In Idle, emul=1 at a rising edge SHALL capture ea (multiplicand) and eb (multiplier), clear the 64-bit accumulator, and enter Run.
REQ-017 Run SHALL perform one shift-add step per clock for exactly 32 clocks; ebusy SHALL be 1 throughout Run and 0 in Idle.
REQ-018 On the 32nd Run edge, the FSM SHALL load ehi/elo with the product, return to Idle, and set emdone=1 for exactly one cycle.
REQ-019 Start-to-result latency SHALL be 33 clock edges from the accepting edge.
REQ-020 emul SHALL be ignored while ebusy=1; operands SHALL NOT be re-sampled during Run.
REQ-021 emul=1 in the emdone cycle SHALL be accepted, allowing back-to-back multiplies with no idle gap.
REQ-022 ehi/elo SHALL hold their last product until the next completion.
REQ-023 The ALU path SHALL be independent of multiplier state.

Reset
REQ-024 resetn=0 SHALL immediately force Idle, counter=0, accumulator=0, ehi=elo=0, emdone=0, ebusy=0, regardless of clock.
REQ-025 Reset mid-Run SHALL abort the operation with no emdone pulse; the first emul after release SHALL start cleanly.

Configuration
REQ-026 Macro EXE_MUL_EN defined: multiplier present per REQ-015..REQ-025.
REQ-027 EXE_MUL_EN undefined: no multiplier logic; emul ignored; ebusy, emdone, ehi, elo tied to 0; ALU behaviour unchanged.

Verification
REQ-028 ealuc=0000, ea=5, eb=7, ealuimm=0 -> ealu=12; ealuc=0100 -> ealu=0xFFFFFFFE.
REQ-029 ealuc=1111, eshift=1, eimm[10:6]=4, eb=0x80000000 -> ealu=0xF8000000; ealuc=0110, ealuimm=1, eimm=0x1234 -> ealu=0x12340000.
REQ-030 ejal=1, epc4=0x100, ern0=0 -> ealu=0x104, ern=31.
REQ-031 emul pulse, ea=0xFFFFFFFF, eb=2 -> ebusy=1 for 32 cycles, then emdone one cycle, ehi=1, elo=0xFFFFFFFE; emul held during Run has no effect.
REQ-032 emul, ea=3, eb=4 accepted in the emdone cycle of a prior op -> next emdone exactly 33 edges later, elo=12, ehi=0.
REQ-033 resetn low at Run cycle 10 -> ebusy=0, ehi=elo=0, no emdone; with EXE_MUL_EN undefined, emul=1 -> ebusy stays 0.
